// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the instruction-fetch path: opcode values,
// fetch sequencer state encoding and default address/data widths.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer (master) and the
// instruction memory (slave). One-cycle ack, data valid with ack.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ack
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads memory at the current PC, latches the
// word into the IR, hands it to the execution stage and drives the PC
// increment/load controls, decoding JMP and HLT locally.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_inc,
    output logic              pc_ld,
    output logic [ADDR_W-1:0] pc_d,
    fetch_sequencer_if.master mem,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ex_ready,
    output logic              halted,
    output logic [15:0]       instr_count
);

    fetch_state_e      state_q,       state_d;
    logic [DATA_W-1:0] ir_q,          ir_d;
    logic              ir_valid_q,    ir_valid_d;
    logic              pc_inc_q,      pc_inc_d;
    logic              pc_ld_q,       pc_ld_d;
    logic [ADDR_W-1:0] pc_load_val_q, pc_load_val_d;
    logic              mem_rd_q,      mem_rd_d;
    logic              halted_q,      halted_d;
    logic [15:0]       instr_count_q, instr_count_d;

    logic [3:0]        opcode;

    assign opcode = ir_q[DATA_W-1 -: 4];

    // The fetch address always follows the PC; only mem_rd qualifies it.
    assign mem.mem_addr = pc_q;
    assign mem.mem_rd   = mem_rd_q;

    assign pc_inc      = pc_inc_q;
    assign pc_ld       = pc_ld_q;
    assign pc_d        = pc_load_val_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d       = state_q;
        ir_d          = ir_q;
        ir_valid_d    = ir_valid_q;
        pc_inc_d      = 1'b0;
        pc_ld_d       = 1'b0;
        pc_load_val_d = pc_load_val_q;
        halted_d      = halted_q;
        instr_count_d = instr_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Wait states are unbounded: the memory decides when to ack.
                if (mem.mem_ack) begin
                    ir_d       = mem.mem_rdata;
                    ir_valid_d = 1'b1;
                    pc_inc_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (ex_ready) begin
                    instr_count_d = instr_count_q + 16'd1;
                    ir_valid_d    = 1'b0;
                    if (opcode == OP_HLT) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else if (opcode == OP_JMP) begin
                        // PC was already incremented past the JMP; keep its page bits.
                        pc_ld_d       = 1'b1;
                        pc_load_val_d = {pc_q[ADDR_W-1:12], ir_q[11:0]};
                        state_d       = ST_SETTLE;
                    end else begin
                        state_d = en ? ST_FETCH : ST_IDLE;
                    end
                end
            end

            ST_SETTLE: begin
                state_d = en ? ST_FETCH : ST_IDLE;
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // mem_rd is registered but tracks FETCH exactly, including the entry cycle.
        mem_rd_d = (state_d == ST_FETCH);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ir_q          <= '0;
            ir_valid_q    <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_ld_q       <= 1'b0;
            pc_load_val_q <= '0;
            mem_rd_q      <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            ir_q          <= ir_d;
            ir_valid_q    <= ir_valid_d;
            pc_inc_q      <= pc_inc_d;
            pc_ld_q       <= pc_ld_d;
            pc_load_val_q <= pc_load_val_d;
            mem_rd_q      <= mem_rd_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a PC register model
// and an instruction memory model with programmable ack delay.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] pc;
    logic        pc_inc;
    logic        pc_ld;
    logic [15:0] pc_d;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ex_ready;
    logic        halted;
    logic [15:0] instr_count;

    fetch_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pc_q        (pc),
        .pc_inc      (pc_inc),
        .pc_ld       (pc_ld),
        .pc_d        (pc_d),
        .mem         (bus),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ex_ready    (ex_ready),
        .halted      (halted),
        .instr_count (instr_count)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register model: inc and ld together means hold.
    logic        preset_en;
    logic [15:0] preset_val;
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 16'h0000;
        else if (preset_en) pc <= preset_val;
        else if (pc_inc && !pc_ld) pc <= pc + 16'd1;
        else if (pc_ld && !pc_inc) pc <= pc_d;
    end

    // Instruction memory model with programmable ack delay and a stray-ack injector.
    logic [15:0] mem_model [0:65535];
    logic        auto_en;
    int          ack_delay;
    int          wait_cnt;
    logic        stray_ack;
    logic [15:0] stray_data;
    logic        auto_ack;
    always_comb begin
        auto_ack      = auto_en && bus.mem_rd && (wait_cnt == ack_delay);
        bus.mem_ack   = auto_ack || stray_ack;
        bus.mem_rdata = stray_ack ? stray_data : mem_model[bus.mem_addr];
    end
    always @(posedge clk) begin
        if (bus.mem_rd && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Event counters sampled at the active edge.
    int pc_inc_cnt = 0;
    int pc_ld_cnt  = 0;
    int overlap_cnt = 0;
    always @(posedge clk) begin
        if (!reset) begin
            if (pc_inc) pc_inc_cnt <= pc_inc_cnt + 1;
            if (pc_ld) pc_ld_cnt <= pc_ld_cnt + 1;
            if (pc_inc && pc_ld) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; ex_ready = 1'b1; auto_en = 1'b1; ack_delay = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if ({pc_inc, pc_ld, pc_d, bus.mem_rd, ir, ir_valid, halted, instr_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: inc=%b ld=%b pc_d=%h rd=%b ir=%h v=%b h=%b cnt=%h, all zero required",
                     pc_inc, pc_ld, pc_d, bus.mem_rd, ir, ir_valid, halted, instr_count);
        end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.mem_rd !== 1'b1) begin
            errors++; $display("FAIL reset_release_rd: got %b want 1", bus.mem_rd);
        end
        checks++;
        if (bus.mem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_release_addr: got %h want 0000", bus.mem_addr);
        end
    endtask

    // Continues from test_reset: cycle 1 of FETCH at address 0.
    task automatic test_sequential();
        logic [15:0] seen_ir [$];
        int          seen_cyc [$];
        int          inc0;
        inc0 = pc_inc_cnt;
        for (int c = 1; c <= 30; c++) begin
            if (ir_valid && ex_ready) begin
                seen_ir.push_back(ir);
                seen_cyc.push_back(c);
            end
            if (halted) break;
            @(negedge clk);
        end
        checks++;
        if (seen_ir.size() != 3) begin
            errors++; $display("FAIL seq_handoffs: got %0d want 3", seen_ir.size());
        end else begin
            checks++;
            if (seen_ir[0] !== 16'h1234) begin errors++; $display("FAIL seq_ir0: got %h want 1234", seen_ir[0]); end
            checks++;
            if (seen_ir[1] !== 16'h2345) begin errors++; $display("FAIL seq_ir1: got %h want 2345", seen_ir[1]); end
            checks++;
            if (seen_ir[2] !== 16'hF000) begin errors++; $display("FAIL seq_ir2: got %h want F000", seen_ir[2]); end
            checks++;
            if (seen_cyc[0] != 2 || seen_cyc[1] != 4 || seen_cyc[2] != 6) begin
                errors++;
                $display("FAIL seq_timing: handoff cycles %0d %0d %0d want 2 4 6", seen_cyc[0], seen_cyc[1], seen_cyc[2]);
            end
        end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL seq_halted: got %b want 1", halted); end
        checks++;
        if (pc_inc_cnt - inc0 != 3) begin errors++; $display("FAIL seq_inc_pulses: got %0d want 3", pc_inc_cnt - inc0); end
        checks++;
        if (pc !== 16'h0003) begin errors++; $display("FAIL seq_pc: got %h want 0003", pc); end
        checks++;
        if (instr_count !== 16'h0003) begin errors++; $display("FAIL seq_count: got %h want 0003", instr_count); end
        @(negedge clk);
        checks++;
        if (bus.mem_rd !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL seq_halt_hold: rd=%b halted=%b want rd=0 halted=1", bus.mem_rd, halted);
        end
    endtask

    task automatic test_jump();
        int ld0, ov0, ld_cyc;
        logic saw_ld;
        mem_model[16'h1010] = 16'hE0A5;
        mem_model[16'h10A5] = 16'hF000;
        auto_en = 1'b1; ack_delay = 0; ex_ready = 1'b1;
        do_reset();
        preset_en = 1'b1; preset_val = 16'h1010;
        @(negedge clk);
        preset_en = 1'b0;
        en = 1'b1;
        ld0 = pc_ld_cnt; ov0 = overlap_cnt;
        saw_ld = 1'b0; ld_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (saw_ld && c == ld_cyc + 1) begin
                checks++;
                if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h10A5) begin
                    errors++; $display("FAIL jmp_target_fetch: rd=%b addr=%h want rd=1 addr=10A5", bus.mem_rd, bus.mem_addr);
                end
            end
            if (pc_ld && !saw_ld) begin
                saw_ld = 1'b1; ld_cyc = c;
                checks++;
                if (pc_d !== 16'h10A5) begin errors++; $display("FAIL jmp_pc_d: got %h want 10A5", pc_d); end
            end
            if (halted) break;
        end
        checks++;
        if (!saw_ld) begin errors++; $display("FAIL jmp_ld_seen: got 0 want 1"); end
        checks++;
        if (pc_ld_cnt - ld0 != 1) begin errors++; $display("FAIL jmp_ld_pulses: got %0d want 1", pc_ld_cnt - ld0); end
        checks++;
        if (overlap_cnt - ov0 != 0) begin errors++; $display("FAIL jmp_inc_ld_overlap: got %0d want 0", overlap_cnt - ov0); end
        checks++;
        if (halted !== 1'b1 || instr_count !== 16'h0002) begin
            errors++; $display("FAIL jmp_end: halted=%b cnt=%h want 1/0002", halted, instr_count);
        end
    endtask

    task automatic test_backpressure();
        int inc0, waited;
        mem_model[16'h0000] = 16'h5678;
        auto_en = 1'b1; ack_delay = 3; ex_ready = 1'b0;
        do_reset();
        en = 1'b1;
        inc0 = pc_inc_cnt;
        @(posedge clk); @(negedge clk);
        waited = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.mem_ack) break;
            checks++;
            if (bus.mem_rd !== 1'b1 || ir !== 16'h0000) begin
                errors++; $display("FAIL bp_wait: rd=%b ir=%h want rd=1 ir=0000", bus.mem_rd, ir);
            end
            waited++;
            @(negedge clk);
        end
        checks++;
        if (waited != 3) begin errors++; $display("FAIL bp_wait_cycles: got %0d want 3", waited); end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ir_valid !== 1'b1 || ir !== 16'h5678 || instr_count !== 16'h0000) begin
                errors++; $display("FAIL bp_stall: v=%b ir=%h cnt=%h want 1/5678/0000", ir_valid, ir, instr_count);
            end
        end
        ex_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_count !== 16'h0001 || ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL bp_handoff: cnt=%h v=%b rd=%b want 0001/0/0", instr_count, ir_valid, bus.mem_rd);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pc_inc_cnt - inc0 != 1 || instr_count !== 16'h0001 || pc !== 16'h0001) begin
            errors++; $display("FAIL bp_once: incs=%0d cnt=%h pc=%h want 1/0001/0001", pc_inc_cnt - inc0, instr_count, pc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        auto_en = 1'b0; ex_ready = 1'b1;
        do_reset();
        en = 1'b1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL mid_fetch_rd: got %b want 1", bus.mem_rd); end
        end
        @(negedge clk);
        reset = 1'b1; en = 1'b0;
        #1;
        checks++;
        if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL mid_reset_rd_drop: got %b want 0", bus.mem_rd); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1; stray_data = 16'hBEEF;
        @(negedge clk);
        stray_ack = 1'b0;
        checks++;
        if (ir !== 16'h0000 || ir_valid !== 1'b0 || dut.state_q !== ST_IDLE || pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: ir=%h v=%b state=%0d inc=%b want 0000/0/IDLE/0", ir, ir_valid, dut.state_q, pc_inc);
        end
        @(negedge clk);
        checks++;
        if (ir !== 16'h0000 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL stray_ack_after: ir=%h rd=%b want 0000/0", ir, bus.mem_rd);
        end
    endtask

    task automatic test_count_wrap();
        logic [15:0] exp_cnt;
        logic        pending;
        int          handoffs;
        mem_model[16'h0000] = 16'h0001;
        mem_model[16'h0001] = 16'hF000;
        auto_en = 1'b1; ack_delay = 0; ex_ready = 1'b1;
        do_reset();
        force dut.instr_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.instr_count_q;
        @(negedge clk);
        checks++;
        if (instr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want FFFF", instr_count); end
        en = 1'b1;
        exp_cnt = 16'hFFFF; pending = 1'b0; handoffs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pending) begin
                exp_cnt = exp_cnt + 16'd1;
                handoffs++;
                checks++;
                if (instr_count !== exp_cnt) begin
                    errors++; $display("FAIL wrap_count_%0d: got %h want %h", handoffs, instr_count, exp_cnt);
                end
            end
            pending = ir_valid && ex_ready;
            if (halted) break;
        end
        checks++;
        if (handoffs != 2 || instr_count !== 16'h0001) begin
            errors++; $display("FAIL wrap_final: handoffs=%0d cnt=%h want 2/0001", handoffs, instr_count);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem_model[a] = 16'h0000;
        mem_model[0] = 16'h1234;
        mem_model[1] = 16'h2345;
        mem_model[2] = 16'hF000;
        preset_en = 1'b0; preset_val = 16'h0000;
        stray_ack = 1'b0; stray_data = 16'h0000;
        auto_en = 1'b0; ack_delay = 0;
        reset = 1'b1; en = 1'b0; ex_ready = 1'b0;

        test_reset();
        test_sequential();
        test_jump();
        test_backpressure();
        test_reset_mid_fetch();
        test_count_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer sitting directly downstream of the 16-bit program counter in the CPU execution unit. It reads the PC value, issues a handshaked read to instruction memory and latches the returned word into the instruction register (IR). It hands the IR to the execution stage with a valid/ready handshake and drives the PC's `inc`/`ld` controls, including local decode of jump and halt opcodes. It is the only block that drives the PC controls.

## Interface
- `ADDR_W`, 16: PC / memory address width
- `DATA_W`, 16: instruction width; opcode is `ir[DATA_W-1 -: 4]`
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: reset, asynchronous, active-high
- `en` in 1: run enable; sampled in IDLE and at each instruction handoff
- `pc_q` in ADDR_W: current PC value
- `pc_inc` out 1: PC increment pulse, registered
- `pc_ld` out 1: PC load pulse, registered
- `pc_d` out ADDR_W: PC load value, registered
- `mem_addr` out ADDR_W: fetch address, equals `pc_q` (combinational passthrough)
- `mem_rd` out 1: read request, high for the whole FETCH state
- `mem_rdata` in DATA_W: read data, valid when `mem_ack` is high
- `mem_ack` in 1: one-cycle read acknowledge
- `ir` out DATA_W: instruction register
- `ir_valid` out 1: IR holds an unconsumed instruction
- `ex_ready` in 1: execution stage accepts IR
- `halted` out 1: HALT executed
- `instr_count` out 16: number of instructions handed off; wraps 0xFFFF→0x0000

## Operation
- States: IDLE, FETCH, ISSUE, SETTLE, HALTED. Encoding is binary and registered.
- Reset (asynchronous): state=IDLE. All outputs are 0: `pc_inc`, `pc_ld`, `pc_d`, `mem_rd`, `ir`, `ir_valid`, `halted`, `instr_count`.
- IDLE: if `en`=1, go to FETCH; otherwise stay.
- FETCH: `mem_rd`=1. On `mem_ack`=1: `ir`←`mem_rdata`, `pc_inc`←1 for one cycle, go to ISSUE. Without `mem_ack` the block waits indefinitely.
- ISSUE: `ir_valid`=1, and `ir` is stable until handoff. Handoff occurs in a cycle with `ex_ready`=1, and increments `instr_count` by 1. Next state after handoff:
  - opcode 4'hF (HLT): go to HALTED, `halted`←1.
  - opcode 4'hE (JMP): `pc_ld`←1 for one cycle, `pc_d`←{`pc_q`[ADDR_W-1:12], `ir`[11:0]}, go to SETTLE.
  - any other opcode, `en`=1: go to FETCH.
  - any other opcode, `en`=0: go to IDLE.
- SETTLE: one cycle while the PC absorbs the load. Then go to FETCH if `en`=1, otherwise IDLE.
- HALTED: terminal. `halted`=1, `mem_rd`=0. Only reset exits.
- `pc_inc` and `pc_ld` are never high in the same cycle. The PC treats both high as hold, so simultaneous assertion is a bug.
- `mem_ack` outside FETCH is ignored; `ir` is unchanged.

## Timing
- Fetch-to-issue latency: `mem_ack` sampled at edge N → `ir`/`ir_valid` valid in cycle N+1, `pc_inc`=1 in cycle N+1, PC updated after edge N+1.
- Earliest handoff is at edge N+1. The next FETCH starts in cycle N+2 with `mem_addr` = incremented PC.
- Sequential throughput with zero-wait memory and `ex_ready` held high: 1 instruction per 2 cycles.
- JMP: handoff at edge M → `pc_ld`=1 in cycle M+1 (SETTLE) → FETCH in cycle M+2 with `mem_addr` = target. JMP costs 3 cycles.
- Reset asserted mid-FETCH: `mem_rd` drops immediately. A late `mem_ack` after reset release is ignored in IDLE.

## Structure
- Shared package `cpu_pkg` holds the constants `OP_JMP`=4'hE and `OP_HLT`=4'hF, the fetch state encoding, and `ADDR_W`/`DATA_W` defaults.
- Single module, no sub-modules; `instr_count` is inline.
- Integration: `pc_inc`→PC `inc`, `pc_ld`→PC `ld`, `pc_d`→PC `D`, PC `Q`→`pc_q`.

## Test plan
- Reset/enable: assert reset with `en`=1 → all outputs 0. Release reset → `mem_rd`=1 and `mem_addr`=0x0000 on the first cycle after the next edge.
- Sequential fetch: memory words 0x1234, 0x2345, 0xF000 at addresses 0–2; zero-wait ack; `ex_ready`=1.
  - Required: IR sequence 0x1234, 0x2345, 0xF000.
  - Required: `pc_inc` pulses 3 times, then `halted`=1, PC=3, `instr_count`=3.
- Jump: word 0xE0A5 at PC 0x1010 → after handoff `pc_ld`=1 with `pc_d`=0x10A5. Next `mem_addr`=0x10A5. `pc_ld` and `pc_inc` are never high together.
- Backpressure and wait states: `mem_ack` delayed 3 cycles and `ex_ready` low for 5 cycles.
  - Required: `mem_rd` stays high until ack; `ir` and `ir_valid` stay stable.
  - Required: no extra `pc_inc`; `instr_count` increments exactly once.
- Reset mid-operation: assert reset in FETCH while waiting for ack, then drive a stray `mem_ack` with data 0xBEEF after release with `en`=0. Required: state stays IDLE and `ir`=0x0000.
- Counter wrap: preload the bench to 0xFFFF handoffs (or force) → next handoff gives `instr_count`=0x0000.
